button_cmd_scheduler: RTL and testbench
=======================================

Name: button_cmd_scheduler

Overview:
- Sequences user commands from multiple debounced push-buttons into one shared command engine (e.g. the SPI flash instruction issuer).
- Detects rising edges on debounced button levels and latches them as pending requests.
- Grants pending requests round-robin, issues exactly one command at a time over a valid/ready handshake, then holds off until the engine signals completion or a timeout expires.
- Sits between the per-button debounce instances and the command/transaction engine.

Parameters:
- N_BTN, 4, number of button inputs (2..8).
- IDX_W, 2, width of cmd_id; must satisfy 2^IDX_W >= N_BTN.
- TO_W, 16, width of the busy-timeout counter.
- TIMEOUT_CYC, 50000, clk cycles allowed in BUSY before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- btn_db  in  N_BTN  debounced button levels, synchronous to clk.
- cmd_ready  in  1  engine accepts the command this cycle when cmd_valid=1.
- cmd_done  in  1  single-cycle pulse: engine finished the accepted command.
- clr_err  in  1  synchronous clear of overflow and timeout_err.
- cmd_valid  out  1  command request to the engine.
- cmd_id  out  IDX_W  index of the granted button; stable while cmd_valid=1.
- busy  out  1  high whenever state != IDLE.
- pending  out  N_BTN  latched, not-yet-granted presses.
- overflow  out  N_BTN  sticky: press arrived while that button was already pending.
- timeout_err  out  1  sticky: BUSY aborted by timeout.

Behaviour:
- Reset values:
  - cmd_valid=0, cmd_id=0, busy=0, pending=0, overflow=0, timeout_err=0.
  - State=IDLE, btn_q=0, timeout counter=0.
  - last_grant=N_BTN-1, so button 0 has first priority.
- Edge detect:
  - btn_q registers btn_db every cycle; press[i] = btn_db[i] & ~btn_q[i].
  - A level already high when reset deasserts counts as one press.
- Pending:
  - pending[i] sets on press[i].
  - pending[i] clears on the edge its grant is taken (IDLE->REQ).
  - If press[i] and clear of i occur on the same edge, pending[i] stays 1.
  - If press[i] occurs while pending[i]=1 and i is not being cleared that edge, set overflow[i]; the press is dropped, not counted.
- Arbitration (IDLE only):
  - If pending != 0, choose the first set bit searching upward from last_grant+1, wrapping modulo N_BTN.
  - On that edge: cmd_id <= winner, last_grant <= winner, cmd_valid <= 1, state <= REQ.
- FSM:
  - IDLE: as above; stays IDLE when pending=0.
  - REQ: cmd_valid=1 and cmd_id held. On an edge with cmd_ready=1: cmd_valid <= 0, timeout counter <= 0, state <= BUSY. cmd_done is ignored in REQ.
  - BUSY:
    - cmd_done=1 -> IDLE.
    - Otherwise, if TIMEOUT_CYC != 0 and the counter has reached TIMEOUT_CYC-1 -> IDLE with timeout_err <= 1.
    - Otherwise counter increments.
    - cmd_done wins over a simultaneous timeout.
- Latency:
  - btn_db first sampled high at edge k -> pending set after k -> cmd_valid=1 after k+1, when idle with nothing else pending.
  - cmd_done at edge m -> IDLE after m -> next grant after m+1.
- clr_err: clears overflow and timeout_err on the next edge. A new overflow or timeout event in the same cycle takes priority, so the bit stays 1.
- Reset mid-operation: returns to IDLE immediately with all pending requests discarded; any in-flight engine command is abandoned.
- cmd_id upper bits are 0 for unused codes; the arbiter never grants an index >= N_BTN.

Test Plan:
- Single press: reset, btn_db=0001 at edge 10 -> pending=0001 after edge 10; cmd_valid=1, cmd_id=0 after edge 11; cmd_ready=1 at edge 13 -> busy, cmd_valid=0; cmd_done at edge 20 -> busy=0 after edge 20.
- Round-robin: press buttons 0, 2 and 3 on the same edge with cmd_ready tied 1 and cmd_done 3 cycles after each accept -> grant order 0, 2, 3. Then press 0 and 3 together -> grant order 0, 3 (last_grant=3, so the search wraps to 0).
- Backpressure: cmd_ready=0 for 50 cycles after cmd_valid -> cmd_valid stays 1 with cmd_id constant throughout; accept occurs only on the cmd_ready=1 edge.
- Overflow: hold the engine in BUSY, press button 1, release, press again -> overflow=0010; only one command issued for button 1. clr_err pulse -> overflow=0.
- Timeout: TIMEOUT_CYC=8, cmd_done never asserted -> busy drops 8 cycles after accept and timeout_err=1. A press pending during the abort is granted on the following cycle.
- Async reset: assert reset while in REQ with pending=1100 -> cmd_valid, busy and pending go to 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/button_cmd_scheduler.sv
// button_cmd_scheduler
//   Collects rising edges from debounced push-buttons as pending requests and
//   feeds them, one at a time and in round-robin order, to a shared command
//   engine. After a command is accepted the block waits in BUSY until the
//   engine reports completion (cmd_done) or the busy timeout expires.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   btn_db       debounced button levels (N_BTN), synchronous to clk
//   cmd_ready    engine accepts the command on an edge where cmd_valid=1
//   cmd_done     one-cycle pulse: engine finished the accepted command
//   clr_err      clears overflow and timeout_err on the next edge
//   cmd_valid    command request to the engine
//   cmd_id       granted button index, stable while cmd_valid=1
//   busy         high whenever the FSM is not IDLE
//   pending      latched presses that have not been granted yet
//   overflow     sticky per button: press seen while already pending
//   timeout_err  sticky: BUSY was aborted by the timeout
//
// Handshake: the command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. Once cmd_valid rises, it and cmd_id hold until that
// transfer edge; cmd_ready is ignored while cmd_valid is 0.
module button_cmd_scheduler #(
  parameter int N_BTN       = 4,
  parameter int IDX_W       = 2,
  parameter int TO_W        = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_db,
  input  logic             cmd_ready,
  input  logic             cmd_done,
  input  logic             clr_err,
  output logic             cmd_valid,
  output logic [IDX_W-1:0] cmd_id,
  output logic             busy,
  output logic [N_BTN-1:0] pending,
  output logic [N_BTN-1:0] overflow,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    BUSY = 2'd2
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  state_t             state_q, state_d;
  logic [N_BTN-1:0]   btn_q, btn_d;
  logic [N_BTN-1:0]   pending_q, pending_d;
  logic [N_BTN-1:0]   overflow_q, overflow_d;
  logic               timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   cmd_id_q, cmd_id_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

  logic [N_BTN-1:0]   press;
  logic [N_BTN-1:0]   clear_mask;
  logic [N_BTN-1:0]   ovf_set;
  logic               grant_take;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic               to_set;

  assign press      = btn_db & ~btn_q;
  assign grant_take = (state_q == IDLE) && (|pending_q);

  // Round-robin search: first pending bit strictly after last_grant, wrapping.
  // k runs 1..N_BTN so last_grant itself is examined last.
  always_comb begin
    int               idx;
    logic [N_BTN-1:0] shifted;
    found   = 1'b0;
    winner  = '0;
    idx     = 0;
    shifted = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx     = (int'(last_grant_q) + k) % N_BTN;
      shifted = pending_q >> idx;
      if (!found && shifted[0]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
  end

  // The grant's pending bit clears on the grant edge; a press on the same
  // edge re-sets it, and is not an overflow because the old request left.
  assign clear_mask = grant_take ? ({{(N_BTN-1){1'b0}}, 1'b1} << winner) : '0;
  assign ovf_set    = press & pending_q & ~clear_mask;

  always_comb begin
    state_d      = state_q;
    btn_d        = btn_db;
    last_grant_d = last_grant_q;
    cmd_id_d     = cmd_id_q;
    cmd_valid_d  = cmd_valid_q;
    to_cnt_d     = to_cnt_q;
    to_set       = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_take) begin
          cmd_id_d     = winner;
          last_grant_d = winner;
          cmd_valid_d  = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          to_cnt_d    = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // Completion outranks a timeout on the same edge.
        if (cmd_done) begin
          state_d = IDLE;
        end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
          state_d = IDLE;
          to_set  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase

    pending_d     = (pending_q & ~clear_mask) | press;
    // A new error event beats clr_err on the same edge.
    overflow_d    = (clr_err ? '0 : overflow_q) | ovf_set;
    timeout_err_d = (clr_err ? 1'b0 : timeout_err_q) | to_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      btn_q         <= '0;
      pending_q     <= '0;
      overflow_q    <= '0;
      timeout_err_q <= 1'b0;
      last_grant_q  <= IDX_W'(N_BTN - 1);
      cmd_id_q      <= '0;
      cmd_valid_q   <= 1'b0;
      to_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      btn_q         <= btn_d;
      pending_q     <= pending_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
      last_grant_q  <= last_grant_d;
      cmd_id_q      <= cmd_id_d;
      cmd_valid_q   <= cmd_valid_d;
      to_cnt_q      <= to_cnt_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_id      = cmd_id_q;
  assign busy        = (state_q != IDLE);
  assign pending     = pending_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_button_cmd_scheduler.sv
module tb_button_cmd_scheduler;

  localparam int N_BTN = 4;
  localparam int IDX_W = 2;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N_BTN-1:0] btn_db = '0;
  logic             cmd_ready = 1'b0;
  logic             cmd_done = 1'b0;
  logic             clr_err = 1'b0;
  logic             cmd_valid;
  logic [IDX_W-1:0] cmd_id;
  logic             busy;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] overflow;
  logic             timeout_err;

  always #5 clk = ~clk;

  button_cmd_scheduler #(
    .N_BTN(N_BTN), .IDX_W(IDX_W), .TO_W(16), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_db(btn_db), .cmd_ready(cmd_ready),
    .cmd_done(cmd_done), .clr_err(clr_err), .cmd_valid(cmd_valid),
    .cmd_id(cmd_id), .busy(busy), .pending(pending), .overflow(overflow),
    .timeout_err(timeout_err)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;
  logic [IDX_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled 1ns after it, inputs driven there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_ready = 1'b0;
    cmd_done = 1'b0;
    clr_err = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  // Step until cmd_valid is seen, at most 10 edges; expiry counts as a failure.
  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cmd_valid) begin
        seen = 1'b1;
        break;
      end
    end
    n_total++;
    if (seen) n_pass++;
    else $display("FAIL %s: cmd_valid got 0 expected 1 within 10 cycles", name);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N_BTN-1:0] btn;
    logic             rdy;
    logic             done;
    logic             clr;
    logic             e_valid;
    logic [IDX_W-1:0] e_id;
    logic             e_busy;
    logic [N_BTN-1:0] e_pend;
    logic [N_BTN-1:0] e_ovf;
    logic             e_to;
  } vec_t;

  vec_t vec[13];

  initial begin
    bit held;

    //          btn     rdy   done  clr   valid id     busy  pend    ovf     to
    vec[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000, 1'b0};
    vec[1]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
    vec[2]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
    vec[3]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000, 1'b0};
    vec[4]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0000, 1'b0};
    vec[5]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0000, 1'b0};
    vec[6]  = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0010, 4'b0010, 1'b0};
    vec[7]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0010, 1'b0};
    vec[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0010, 1'b0};
    vec[9]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0010, 1'b0};
    vec[10] = '{4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000, 1'b0};
    vec[11] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000, 1'b0};
    vec[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000, 1'b0};

    // ---- reset state ----
    do_reset();
    check("rst cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst cmd_id", 32'(cmd_id), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst pending", 32'(pending), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst timeout_err", 32'(timeout_err), 32'd0);

    // ---- single press, overflow, clr_err (table) ----
    for (int i = 0; i < 13; i++) begin
      btn_db    = vec[i].btn;
      cmd_ready = vec[i].rdy;
      cmd_done  = vec[i].done;
      clr_err   = vec[i].clr;
      step();
      check($sformatf("vec%0d cmd_valid", i), 32'(cmd_valid), 32'(vec[i].e_valid));
      check($sformatf("vec%0d cmd_id", i), 32'(cmd_id), 32'(vec[i].e_id));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vec[i].e_busy));
      check($sformatf("vec%0d pending", i), 32'(pending), 32'(vec[i].e_pend));
      check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vec[i].e_ovf));
      check($sformatf("vec%0d timeout_err", i), 32'(timeout_err), 32'(vec[i].e_to));
    end
    btn_db = '0; cmd_ready = 1'b0; cmd_done = 1'b0; clr_err = 1'b0;

    // ---- round-robin: fresh reset so last_grant = 3 ----
    do_reset();
    cmd_ready = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        btn_db = 4'b1101;
        exp_q.push_back(2'd0); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
      end else begin
        btn_db = 4'b1001;
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
      end
      step();
      check($sformatf("rr%0d pending", pass), 32'(pending), 32'(btn_db));
      btn_db = '0;
      while (exp_q.size() > 0) begin
        logic [IDX_W-1:0] e;
        e = exp_q.pop_front();
        wait_valid("rr valid");
        check($sformatf("rr%0d grant", pass), 32'(cmd_id), 32'(e));
        step();  // accept edge
        check("rr accepted", 32'({busy, cmd_valid}), 32'b10);
        step();
        step();
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
        check("rr done busy", 32'(busy), 32'd0);
      end
    end
    cmd_ready = 1'b0;

    // ---- backpressure: 50 cycles with cmd_ready low ----
    btn_db = 4'b0100;
    step();
    btn_db = '0;
    wait_valid("bp valid");
    check("bp id", 32'(cmd_id), 32'd2);
    held = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (!(cmd_valid === 1'b1 && cmd_id === 2'd2 && busy === 1'b1)) held = 1'b0;
    end
    check("bp held 50 cycles", 32'(held), 32'd1);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("bp accept", 32'({busy, cmd_valid}), 32'b10);
    cmd_done = 1'b1;
    step();
    cmd_done = 1'b0;
    check("bp done", 32'(busy), 32'd0);

    // ---- timeout with TIMEOUT_CYC = 8 ----
    btn_db = 4'b0010;
    step();                              // edge p
    check("to pending", 32'(pending), 32'b0010);
    btn_db = '0;
    cmd_ready = 1'b1;
    step();                              // p+1
    check("to valid", 32'({cmd_valid, cmd_id}), 32'b101);
    step();                              // p+2 accept
    check("to accept", 32'({busy, cmd_valid}), 32'b10);
    cmd_ready = 1'b0;
    btn_db = 4'b1000;
    step();                              // p+3
    check("to pend3", 32'(pending), 32'b1000);
    btn_db = '0;
    repeat (6) step();                   // p+9
    check("to busy before", 32'({busy, timeout_err}), 32'b10);
    step();                              // p+10 timeout
    check("to busy after", 32'(busy), 32'd0);
    check("to timeout_err", 32'(timeout_err), 32'd1);
    step();                              // p+11 next grant
    check("to regrant", 32'({cmd_valid, cmd_id}), 32'b111);
    check("to regrant pend", 32'(pending), 32'd0);

    // ---- async reset while in REQ with pending=1100 ----
    btn_db = 4'b1100;
    step();
    check("ar pending", 32'(pending), 32'b1100);
    #3;
    reset = 1'b1;
    #1;
    check("ar cmd_valid", 32'(cmd_valid), 32'd0);
    check("ar busy", 32'(busy), 32'd0);
    check("ar pending0", 32'(pending), 32'd0);
    check("ar timeout_err", 32'(timeout_err), 32'd0);
    // Levels still high at reset release count as presses.
    step();
    reset = 1'b0;
    step();
    check("ar level press", 32'(pending), 32'b1100);
    step();
    check("ar first grant", 32'({cmd_valid, cmd_id}), 32'b110);
    btn_db = '0;

    // ---- final report ----
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
